div_unit: RTL

- Multicycle signed 32-bit divider for the multicycle CPU datapath. It implements DIV and writes the quotient to LO and the remainder to HI.
- Operands come from the register file A/B latches, the same values the ALU operand selectors see.
- The control unit starts it with a one-cycle pulse, then holds its FSM until done pulses.
- Restoring algorithm, one quotient bit per clock.

---
 rtl/div_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider (DIV -> LO quotient, HI remainder)
//
// Purpose:
//   Signed WIDTH-bit divide for the multicycle CPU datapath. A one-cycle
//   start pulse in IDLE latches the operands; one quotient bit is produced
//   per clock using the restoring algorithm on magnitudes. A final SIGN step
//   applies MIPS sign rules: the quotient truncates toward zero and the
//   remainder takes the sign of the dividend.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset, clears all state
//   start     in   one-cycle request, only honoured in IDLE
//   dividend  in   signed dividend (rs), sampled on the accepting edge
//   divisor   in   signed divisor (rt), sampled on the accepting edge
//   hi_out    out  remainder, held until the next successful divide
//   lo_out    out  quotient, held until the next successful divide
//   busy      out  high whenever the unit is not IDLE
//   done      out  one-cycle completion pulse
//   div_zero  out  divide-by-zero flag, sticky until a nonzero-divisor start
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] abs_dividend;
   logic [WIDTH-1:0] abs_divisor;
   logic [WIDTH-1:0] shift_rem;
   logic [WIDTH:0]   trial;

   // Magnitudes are treated as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
   always_comb begin
      abs_dividend = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
      abs_divisor  = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
   end

   // The remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
   // so its MSB is zero and the shifted value still fits in WIDTH bits.
   // The extra trial bit is the borrow that selects restore vs. keep.
   always_comb begin
      shift_rem = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      trial     = {1'b0, shift_rem} - {1'b0, dvs_q};
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r <= dividend[WIDTH-1];
                  dvs_q  <= abs_divisor;
                  if (divisor == '0) begin
                     // Zero divisor: skip straight to completion, results untouched.
                     div_zero <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     div_zero <= 1'b0;
                     rem_q    <= '0;
                     quo_q    <= abs_dividend;
                     cnt      <= CNT_W'(WIDTH);
                     state    <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (!trial[WIDTH]) begin
                  rem_q <= trial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= shift_rem;
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= S_SIGN;
               end
            end
            S_SIGN: begin
               lo_out <= sign_q ? (~quo_q + WIDTH'(1)) : quo_q;
               hi_out <= sign_r ? (~rem_q + WIDTH'(1)) : rem_q;
               state  <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
